// File: rtl/modport_regfile.sv
// Host-bus control/status register block: ID/VERSION constants, CTRL, an 8-bit
// event counter with a sticky wrap flag, and eight scratch registers.
module modport_regfile (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sel,
    input  logic       wr,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    localparam logic [7:0] ID_VAL      = 8'hA5;
    localparam logic [7:0] VERSION_VAL = 8'h01;

    localparam logic [3:0] A_ID      = 4'h0;
    localparam logic [3:0] A_VERSION = 4'h1;
    localparam logic [3:0] A_CTRL    = 4'h2;
    localparam logic [3:0] A_COUNT   = 4'h3;
    localparam logic [3:0] A_STATUS  = 4'h4;

    logic [7:0] r_ctrl;
    logic [7:0] r_count;
    logic       r_wrap;
    logic [7:0] r_scratch [0:7];
    logic [7:0] r_rdata;

    logic       w_wr_en;
    logic       w_rd_en;
    logic       w_ctrl_wr;
    logic       w_clr;
    logic       w_w1c;
    logic       w_inc;
    logic       w_wrap_evt;
    logic [7:0] w_rd_val;

    assign w_wr_en    = sel & wr;
    assign w_rd_en    = sel & ~wr;
    assign w_ctrl_wr  = w_wr_en & (addr == A_CTRL);
    assign w_clr      = w_ctrl_wr & wdata[1];
    assign w_w1c      = w_wr_en & (addr == A_STATUS) & wdata[0];
    assign w_inc      = r_ctrl[0];
    // A clear in the same edge suppresses the increment, so it cannot wrap either.
    assign w_wrap_evt = w_inc & ~w_clr & (r_count == 8'hFF);

    // NOTE: default first so every path assigns w_rd_val and no latch is inferred.
    always_comb begin
        w_rd_val = 8'h00;
        if (addr[3]) begin
            w_rd_val = r_scratch[addr[2:0]];
        end else begin
            case (addr)
                A_ID:     w_rd_val = ID_VAL;
                A_VERSION:w_rd_val = VERSION_VAL;
                A_CTRL:   w_rd_val = r_ctrl;
                A_COUNT:  w_rd_val = r_count;
                A_STATUS: w_rd_val = {7'b0, r_wrap};
                default:  w_rd_val = 8'h00;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // see pre-edge values of each other.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ctrl <= 8'h00;
        end else if (w_ctrl_wr) begin
            r_ctrl <= {wdata[7:2], 1'b0, wdata[0]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= 8'h00;
        end else if (w_clr) begin
            r_count <= 8'h00;
        end else if (w_inc) begin
            r_count <= r_count + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrap <= 1'b0;
        end else if (w_wrap_evt) begin
            r_wrap <= 1'b1;
        end else if (w_w1c) begin
            r_wrap <= 1'b0;
        end
    end

    // NOTE: the scratch array is reset because software expects it to read 0
    // after reset; with only eight entries it stays in flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                r_scratch[i] <= 8'h00;
            end
        end else if (w_wr_en && addr[3]) begin
            r_scratch[addr[2:0]] <= wdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata <= 8'h00;
        end else if (w_rd_en) begin
            r_rdata <= w_rd_val;
        end
    end

    assign rdata = r_rdata;

endmodule

// File: tb/tb_modport_regfile.sv
// Directed table plus hand sequences for modport_regfile, followed by random
// traffic checked against a small register model.
module tb_modport_regfile;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       sel;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       sel;
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic       chk;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    logic [7:0] m_ctrl;
    logic [7:0] m_count;
    logic       m_wrap;
    logic [7:0] m_scr [0:7];
    logic [7:0] m_rdata;

    modport_regfile dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .sel   (sel),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: rdata=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic w, input logic [3:0] a,
                       input logic [7:0] d, input logic c, input logic [7:0] e);
        vec_t v;
        v.sel = s; v.wr = w; v.addr = a; v.wdata = d; v.chk = c; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] e);
        add(1'b1, 1'b0, a, 8'h00, 1'b1, e);
    endtask

    task automatic wrt(input logic [3:0] a, input logic [7:0] d);
        add(1'b1, 1'b1, a, d, 1'b0, 8'h00);
    endtask

    task automatic wrt_hold(input logic [3:0] a, input logic [7:0] d, input logic [7:0] e);
        add(1'b1, 1'b1, a, d, 1'b1, e);
    endtask

    task automatic idle_v(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00);
    endtask

    // Drive one bus cycle from just after an edge; returns #1 after the next edge.
    task automatic drive(input logic s, input logic w, input logic [3:0] a, input logic [7:0] d);
        sel = s; wr = w; addr = a; wdata = d;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [7:0] e, input string name);
        drive(1'b1, 1'b0, a, 8'h00);
        check(name, rdata, e);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        drive(1'b1, 1'b1, a, d);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    // Reference behaviour of one clock edge, computed from pre-edge model state.
    task automatic model_step(input logic s, input logic w, input logic [3:0] a, input logic [7:0] d);
        logic [7:0] rv;
        logic       clr;
        logic       wrap_now;
        case (a)
            4'h0: rv = 8'hA5;
            4'h1: rv = 8'h01;
            4'h2: rv = m_ctrl;
            4'h3: rv = m_count;
            4'h4: rv = {7'b0, m_wrap};
            4'h5, 4'h6, 4'h7: rv = 8'h00;
            default: rv = m_scr[a - 4'h8];
        endcase
        clr      = s && w && (a == 4'h2) && d[1];
        wrap_now = m_ctrl[0] && !clr && (m_count == 8'hFF);
        if (clr) m_count = 8'h00;
        else if (m_ctrl[0]) m_count = m_count + 8'd1;
        if (wrap_now) m_wrap = 1'b1;
        else if (s && w && (a == 4'h4) && d[0]) m_wrap = 1'b0;
        if (s && w && (a == 4'h2)) m_ctrl = {d[7:2], 1'b0, d[0]};
        if (s && w && a >= 4'h8) m_scr[a - 4'h8] = d;
        if (s && !w) m_rdata = rv;
    endtask

    initial begin
        rst_i = 1'b1; sel = 1'b0; wr = 1'b0; addr = 4'h0; wdata = 8'h00;
        #12;
        check("reset_rdata", rdata, 8'h00);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Reset values, constants, scratch, RO/reserved write protection.
        rd(4'h0, 8'hA5);
        rd(4'h1, 8'h01);
        rd(4'h4, 8'h00);
        rd(4'h9, 8'h00);
        wrt_hold(4'hA, 8'h3C, 8'h00);
        rd(4'hA, 8'h3C);
        wrt_hold(4'h0, 8'hFF, 8'h3C);
        wrt_hold(4'h6, 8'hFF, 8'h3C);
        rd(4'h0, 8'hA5);
        rd(4'h6, 8'h00);
        rd(4'h2, 8'h00);
        rd(4'h3, 8'h00);
        wrt(4'h8, 8'h5A);
        wrt(4'hF, 8'hC3);
        rd(4'h8, 8'h5A);
        rd(4'hF, 8'hC3);
        add(1'b0, 1'b1, 4'h8, 8'h11, 1'b1, 8'hC3);
        rd(4'h8, 8'h5A);
        // Counter: EN from the edge after the write, CLR in the write edge.
        wrt(4'h2, 8'h01);
        idle_v(9);
        add(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'h5A);
        rd(4'h3, 8'h0A);
        rd(4'h2, 8'h01);
        wrt(4'h2, 8'h03);
        rd(4'h3, 8'h00);
        rd(4'h2, 8'h01);
        wrt(4'h2, 8'h00);
        rd(4'h3, 8'h03);
        idle_v(1);
        rd(4'h3, 8'h03);
        // CTRL storage bits and CLR reading back as 0.
        wrt(4'h2, 8'hFC);
        rd(4'h2, 8'hFC);
        wrt(4'h2, 8'hFE);
        rd(4'h2, 8'hFC);
        rd(4'h3, 8'h00);
        wrt(4'h3, 8'h77);
        rd(4'h3, 8'h00);
        wrt(4'h4, 8'h01);
        rd(4'h4, 8'h00);
        wrt(4'h2, 8'h00);
        rd(4'h2, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk) check($sformatf("vec%0d", i), rdata, vecs[i].exp);
        end

        // Wrap sets the sticky flag; W1C clears it; a simultaneous wrap wins.
        do_write(4'h2, 8'h01);
        idle_n(260);
        do_read(4'h4, 8'h01, "wrap_sticky");
        do_write(4'h4, 8'h01);
        do_read(4'h4, 8'h00, "wrap_w1c");
        do_write(4'h2, 8'h03);
        idle_n(255);
        do_write(4'h4, 8'h01);
        do_read(4'h4, 8'h01, "wrap_beats_w1c");
        do_read(4'h3, 8'h01, "count_after_wrap");
        do_write(4'h2, 8'h00);

        // Asynchronous reset in the middle of a read, between clock edges.
        do_write(4'hB, 8'h66);
        do_write(4'h2, 8'h81);
        do_read(4'hB, 8'h66, "pre_reset_read");
        sel = 1'b1; wr = 1'b0; addr = 4'hB;
        #3;
        rst_i = 1'b1;
        #1;
        check("reset_async_rdata", rdata, 8'h00);
        @(posedge clk_i);
        #1;
        check("reset_hold_rdata", rdata, 8'h00);
        sel = 1'b0;
        rst_i = 1'b0;
        do_read(4'hB, 8'h00, "reset_scratch");
        do_read(4'h2, 8'h00, "reset_ctrl");
        do_read(4'h3, 8'h00, "reset_count");
        idle_n(3);
        do_read(4'h3, 8'h00, "count_stopped");
        do_read(4'h4, 8'h00, "reset_status");

        // Random traffic against the reference model, starting from reset state.
        m_ctrl = 8'h00; m_count = 8'h00; m_wrap = 1'b0; m_rdata = 8'h00;
        for (int i = 0; i < 8; i++) m_scr[i] = 8'h00;
        for (int i = 0; i < 2000; i++) begin
            logic       s;
            logic       w;
            logic [3:0] a;
            logic [7:0] d;
            s = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 1) == 1);
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            model_step(s, w, a, d);
            drive(s, w, a, d);
            check($sformatf("rand%0d", i), rdata, m_rdata);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
